// File: rtl/msg_receive_arbiter_if.sv
// Bundle of FIFO read-side, header, payload-stream and error signals of msg_receive_arbiter.
// The arbiter takes the master modport; the FIFOs and consumers sit behind the slave modport.
interface msg_receive_arbiter_if #(
    parameter int CHANNEL    = 6,
    parameter int DATA_WIDTH = 128
);
    logic [CHANNEL-1:0]            rd_en_o;
    logic [CHANNEL*DATA_WIDTH-1:0] rd_din_i;
    logic [CHANNEL-1:0]            rd_empty_i;

    logic                          hdr_valid_o;
    logic [3:0]                    hdr_chan_o;
    logic [7:0]                    hdr_src_id_o;
    logic [7:0]                    hdr_des_id_o;
    logic [7:0]                    hdr_data_type_o;
    logic [7:0]                    hdr_data_channel_o;
    logic [15:0]                   hdr_field_len_o;

    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [DATA_WIDTH-1:0]         out_data_o;
    logic                          out_sof_o;
    logic                          out_eof_o;
    logic [3:0]                    out_chan_o;
    logic [1:0]                    out_class_o;

    logic                          err_type_o;
    logic                          err_len_o;
    logic [15:0]                   drop_cnt_o;

    modport master (
        output rd_en_o,
        input  rd_din_i, rd_empty_i,
        output hdr_valid_o, hdr_chan_o, hdr_src_id_o, hdr_des_id_o,
        output hdr_data_type_o, hdr_data_channel_o, hdr_field_len_o,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o, out_sof_o, out_eof_o, out_chan_o, out_class_o,
        output err_type_o, err_len_o, drop_cnt_o
    );

    modport slave (
        input  rd_en_o,
        output rd_din_i, rd_empty_i,
        input  hdr_valid_o, hdr_chan_o, hdr_src_id_o, hdr_des_id_o,
        input  hdr_data_type_o, hdr_data_channel_o, hdr_field_len_o,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o, out_sof_o, out_eof_o, out_chan_o, out_class_o,
        input  err_type_o, err_len_o, drop_cnt_o
    );
endinterface

// File: rtl/msg_receive_arbiter.sv
// Frame-atomic round-robin drain of CHANNEL FWFT message FIFOs with one shared header parser,
// a back-pressured payload stream and drop handling for bad type / bad length frames.
//
// state   | meaning
// IDLE    | waiting for any non-empty FIFO
// ARB     | pick next non-empty channel after last_grant
// HDR     | pop and parse header beat of granted channel
// PAYLOAD | forward payload beats to the output register
// DROP    | discard remaining beats of a rejected frame
module msg_receive_arbiter #(
    parameter int         CHANNEL        = 6,
    parameter int         DATA_WIDTH     = 128,
    parameter int         MAX_BEATS      = 256,
    parameter logic [7:0] TYPE_US_TIMING = 8'h01,
    parameter logic [7:0] TYPE_DS_BURST  = 8'h02,
    parameter logic [7:0] TYPE_US_BURST  = 8'h03
) (
    input logic                 sys_clk_i,
    input logic                 rst_i,
    msg_receive_arbiter_if.master bus
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int BSH = $clog2(BPB);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_HDR, S_PAYLOAD, S_DROP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            grant_q, grant_d;
    logic [3:0]            last_grant_q, last_grant_d;
    logic [16:0]           cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic [1:0]            class_q, class_d;

    logic                  hdr_valid_q, hdr_valid_d;
    logic [3:0]            hdr_chan_q, hdr_chan_d;
    logic [7:0]            hdr_src_q, hdr_src_d;
    logic [7:0]            hdr_des_q, hdr_des_d;
    logic [7:0]            hdr_type_q, hdr_type_d;
    logic [7:0]            hdr_dch_q, hdr_dch_d;
    logic [15:0]           hdr_len_q, hdr_len_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;
    logic [3:0]            out_chan_q, out_chan_d;
    logic [1:0]            out_class_q, out_class_d;

    logic                  err_type_q, err_type_d;
    logic                  err_len_q, err_len_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    // Pad to 16 channels (missing ones read as empty) so a 4-bit grant indexes cleanly.
    logic [15:0]           empty_ext;
    logic [DATA_WIDTH-1:0] din_arr [16];
    logic [DATA_WIDTH-1:0] head;
    logic                  gnt_empty;
    logic [7:0]            f_type;
    logic [15:0]           f_len;
    logic [16:0]           beats;
    logic [16:0]           drop_beats;
    logic                  type_ok;
    logic [1:0]            f_class;
    logic                  arb_found;
    logic [3:0]            arb_idx;
    logic [3:0]            cand;
    logic                  pop;
    logic [CHANNEL-1:0]    rd_en;

    always_comb begin
        empty_ext = '1;
        for (int i = 0; i < 16; i++) din_arr[i] = '0;
        for (int i = 0; i < CHANNEL; i++) begin
            empty_ext[i] = bus.rd_empty_i[i];
            din_arr[i]   = bus.rd_din_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign head       = din_arr[grant_q];
    assign gnt_empty  = empty_ext[grant_q];
    assign f_type     = head[DATA_WIDTH-17 -: 8];
    assign f_len      = head[DATA_WIDTH-33 -: 16];
    assign beats      = (17'(f_len) + 17'(BPB - 1)) >> BSH;
    assign drop_beats = (beats > 17'(MAX_BEATS)) ? 17'(MAX_BEATS) : beats;

    always_comb begin
        type_ok = 1'b1;
        f_class = 2'd0;
        if (f_type == TYPE_US_TIMING)     f_class = 2'd1;
        else if (f_type == TYPE_DS_BURST) f_class = 2'd2;
        else if (f_type == TYPE_US_BURST) f_class = 2'd3;
        else                              type_ok = 1'b0;
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= CHANNEL; k++) begin
            cand = 4'((int'(last_grant_q) + k) % CHANNEL);
            if (!arb_found && !empty_ext[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        class_d      = class_q;
        hdr_valid_d  = 1'b0;
        hdr_chan_d   = hdr_chan_q;
        hdr_src_d    = hdr_src_q;
        hdr_des_d    = hdr_des_q;
        hdr_type_d   = hdr_type_q;
        hdr_dch_d    = hdr_dch_q;
        hdr_len_d    = hdr_len_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sof_d    = out_sof_q;
        out_eof_d    = out_eof_q;
        out_chan_d   = out_chan_q;
        out_class_d  = out_class_q;
        err_type_d   = 1'b0;
        err_len_d    = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        pop          = 1'b0;

        // The output register drains independently of the FSM, so an EOF beat may linger past IDLE.
        if (out_valid_q && bus.out_ready_i) out_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (empty_ext != '1) state_d = S_ARB;
            end
            S_ARB: begin
                if (arb_found) begin
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                    state_d      = S_HDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (!gnt_empty) begin
                    pop         = 1'b1;
                    hdr_valid_d = 1'b1;
                    hdr_chan_d  = grant_q;
                    hdr_src_d   = head[DATA_WIDTH-1 -: 8];
                    hdr_des_d   = head[DATA_WIDTH-9 -: 8];
                    hdr_type_d  = f_type;
                    hdr_dch_d   = head[DATA_WIDTH-25 -: 8];
                    hdr_len_d   = f_len;
                    class_d     = f_class;
                    if (!type_ok || beats == 17'd0 || beats > 17'(MAX_BEATS)) begin
                        err_type_d = !type_ok;
                        err_len_d  = type_ok;
                        cnt_d      = drop_beats;
                        drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                        state_d    = S_DROP;
                    end else begin
                        cnt_d   = beats;
                        first_d = 1'b1;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!gnt_empty && (!out_valid_q || bus.out_ready_i)) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = head;
                    out_sof_d   = first_q;
                    out_eof_d   = (cnt_q == 17'd1);
                    out_chan_d  = grant_q;
                    out_class_d = class_q;
                    first_d     = 1'b0;
                    cnt_d       = cnt_q - 17'd1;
                    if (cnt_q == 17'd1) state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (cnt_q == 17'd0) begin
                    state_d = S_IDLE;
                end else if (!gnt_empty) begin
                    pop   = 1'b1;
                    cnt_d = cnt_q - 17'd1;
                    if (cnt_q == 17'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en = '0;
        for (int i = 0; i < CHANNEL; i++) rd_en[i] = pop && (grant_q == 4'(i));
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= 4'(CHANNEL - 1);
            cnt_q        <= '0;
            first_q      <= 1'b0;
            class_q      <= '0;
            hdr_valid_q  <= 1'b0;
            hdr_chan_q   <= '0;
            hdr_src_q    <= '0;
            hdr_des_q    <= '0;
            hdr_type_q   <= '0;
            hdr_dch_q    <= '0;
            hdr_len_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_chan_q   <= '0;
            out_class_q  <= '0;
            err_type_q   <= 1'b0;
            err_len_q    <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            class_q      <= class_d;
            hdr_valid_q  <= hdr_valid_d;
            hdr_chan_q   <= hdr_chan_d;
            hdr_src_q    <= hdr_src_d;
            hdr_des_q    <= hdr_des_d;
            hdr_type_q   <= hdr_type_d;
            hdr_dch_q    <= hdr_dch_d;
            hdr_len_q    <= hdr_len_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            out_chan_q   <= out_chan_d;
            out_class_q  <= out_class_d;
            err_type_q   <= err_type_d;
            err_len_q    <= err_len_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.rd_en_o            = rd_en;
    assign bus.hdr_valid_o        = hdr_valid_q;
    assign bus.hdr_chan_o         = hdr_chan_q;
    assign bus.hdr_src_id_o       = hdr_src_q;
    assign bus.hdr_des_id_o       = hdr_des_q;
    assign bus.hdr_data_type_o    = hdr_type_q;
    assign bus.hdr_data_channel_o = hdr_dch_q;
    assign bus.hdr_field_len_o    = hdr_len_q;
    assign bus.out_valid_o        = out_valid_q;
    assign bus.out_data_o         = out_data_q;
    assign bus.out_sof_o          = out_sof_q;
    assign bus.out_eof_o          = out_eof_q;
    assign bus.out_chan_o         = out_chan_q;
    assign bus.out_class_o        = out_class_q;
    assign bus.err_type_o         = err_type_q;
    assign bus.err_len_o          = err_len_q;
    assign bus.drop_cnt_o         = drop_cnt_q;
endmodule

// File: doc/msg_receive_arbiter.md
# msg_receive_arbiter

Parametrised successor to the per-channel message receiver. It drains CHANNEL first-word-fall-through (FWFT) message FIFOs through one frame-atomic round-robin arbiter and parses the header beat of each frame. Frames are classified by data_type, and payload beats go out on a single back-pressured stream tagged with channel and class. Sits between the per-link receive FIFOs and the timing/burst consumers. It replaces per-channel parsers with one shared parser and adds back-pressure, length checking and drop handling.

## Interface
- CHANNEL, 6: number of input FIFOs (1..16).
- DATA_WIDTH, 128: beat width in bits; power of two, 64..512.
- MAX_BEATS, 256: largest legal payload length in beats.
- TYPE_US_TIMING, 8'h01 / TYPE_DS_BURST, 8'h02 / TYPE_US_BURST, 8'h03: data_type codes.
- sys_clk_i  in  1  single clock; FIFO read side also runs on it.
- rst_i  in  1  asynchronous, active-high reset.
- rd_en_o  out  CHANNEL  per-FIFO pop (FWFT).
- rd_din_i  in  CHANNEL*DATA_WIDTH  FIFO heads, channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- rd_empty_i  in  CHANNEL  per-FIFO empty.
- hdr_valid_o  out  1  one-cycle pulse on each accepted header.
- hdr_chan_o  out  4  channel index of the last header.
- hdr_src_id_o / hdr_des_id_o / hdr_data_type_o / hdr_data_channel_o  out  8 each  last header fields.
- hdr_field_len_o  out  16  last header length in bytes.
- out_valid_o  out  1  payload beat valid.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  DATA_WIDTH  payload beat.
- out_sof_o / out_eof_o  out  1  first / last beat of frame.
- out_chan_o  out  4  source channel of the beat.
- out_class_o  out  2  1=us_timing, 2=ds_burst, 3=us_burst.
- err_type_o / err_len_o  out  1  one-cycle pulse when a frame is dropped.
- drop_cnt_o  out  16  saturating count of dropped frames.

## Operation
- Header beat, MSB first: [DW-1-:8] src_id, [DW-9-:8] des_id, [DW-17-:8] data_type, [DW-25-:8] data_channel, [DW-33-:16] field_len; remaining bits ignored.
- beats = ceil(field_len / (DATA_WIDTH/8)), computed 17 bits wide.
- States:
  - IDLE: if any FIFO is non-empty, go to ARB.
  - ARB: grant = first non-empty channel searching from last_grant+1 modulo CHANNEL; go to HDR.
  - HDR: pop one beat, latch fields, pulse hdr_valid_o, then:
    - data_type not one of the three codes: pulse err_type_o, go to DROP.
    - beats==0 or beats>MAX_BEATS: pulse err_len_o, go to DROP.
    - otherwise go to PAYLOAD with beat counter = beats.
    - If the type is also bad, the length check is skipped and only err_type_o fires.
  - PAYLOAD: pop while !empty[grant] && (!out_valid_o || out_ready_i); each pop loads the output register and decrements the counter. First beat sets out_sof_o, counter==1 sets out_eof_o. After the last pop go to IDLE.
  - DROP: pop one beat per cycle while !empty[grant], discarding data, until counter reaches 0; then go to IDLE. If beats==0 the header alone is consumed. If the type is bad, counter = min(beats, MAX_BEATS).
- On every drop, drop_cnt_o increments and saturates at 16'hFFFF.
- The grant is held for the whole frame. Other channels are never popped mid-frame.
- An empty granted FIFO mid-frame stalls indefinitely; there is no timeout.
- rd_en_o is never asserted on an empty FIFO and never on a non-granted channel.

## Timing
- Reset: all outputs 0, state IDLE, last_grant = CHANNEL-1 (so channel 0 is served first), drop_cnt_o = 0.
- rd_en_o is combinational from state, grant, empty and out_ready_i. All other outputs are registered.
- Latency, FIFO non-empty to header pop: IDLE→ARB→HDR = header popped in the 3rd cycle. hdr_valid_o and the fields appear the cycle after the pop.
- Payload pop to out_valid_o: 1 cycle. With out_ready_i held high the stream sustains 1 beat per cycle.
- Handshake: a beat transfers when out_valid_o && out_ready_i. out_data_o, out_sof_o, out_eof_o, out_chan_o and out_class_o stay stable while valid && !ready.
- After the EOF pop, the FSM returns to IDLE while the EOF beat may still be awaiting ready. The next frame's header may be popped, but its payload waits on the output register.
- The header fields hold until the next hdr_valid_o.
- Reset mid-frame clears all state at once. Upstream FIFOs must be reset in the same domain event, because partial frames are not resynchronised.

## Test plan
- Channel 2 only, header type 8'h02, len 48, DW=128 → 3 beats; out_sof_o on beat 0, out_eof_o on beat 2, out_chan_o=2, out_class_o=2, hdr_field_len_o=48.
- Channels 0, 1 and 3 each hold two 1-beat frames (len 16) → service order 0,1,3,0,1,3; no beats of different frames interleaved.
- Type 8'h7F, len 32 → err_type_o pulses, 2 payload beats popped, no out_valid_o, drop_cnt_o=1; the next frame on the same channel passes normally.
- len 0, then len 16*(MAX_BEATS+1) with a valid type → err_len_o twice; header-only frame consumes 1 beat, the oversize frame consumes MAX_BEATS+1 beats; drop_cnt_o=2.
- 4-beat frame with out_ready_i toggling 1,0,0,1,... → all 4 beats delivered in order, output held stable during stalls, rd_en_o never asserted while valid && !ready.
- rst_i asserted for 1 cycle mid-payload → all outputs 0 the same cycle; after release channel 0 is granted first.
